// File: rtl/uart_rx_word_packer.sv
// Packs the UART receiver byte stream into WORD_BYTES-wide words and presents them
// on a valid/ready port. Partial words are dropped on frame end or idle timeout.
module uart_rx_word_packer #(
    parameter int  WORD_BYTES  = 4,
    parameter bit  LSB_FIRST   = 1'b0,
    parameter int  TIMEOUT_CYC = 1000,
    localparam int W           = 8 * WORD_BYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data_i,
    input  logic         rx_data_valid_i,
    input  logic         rx_frame_end_i,
    input  logic         word_ready_i,
    output logic [W-1:0] word_data_o,
    output logic         word_valid_o,
    output logic [15:0]  byte_cnt_o,
    output logic         partial_drop_o,
    output logic         overflow_o
);

    localparam logic [15:0] LAST_BYTE = 16'(WORD_BYTES - 1);
    localparam int          TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [W-1:0]  sh_q,           sh_d;
    logic [15:0]   byte_cnt_q,     byte_cnt_d;
    logic [TW-1:0] idle_q,         idle_d;
    logic [W-1:0]  word_data_q,    word_data_d;
    logic          word_valid_q,   word_valid_d;
    logic          partial_drop_q, partial_drop_d;
    logic          overflow_q,     overflow_d;

    logic [W-1:0]  sh_acc;
    logic          accept;
    logic          complete;
    logic          transfer;
    logic          timeout_hit;
    logic          frame_drop;
    logic          drop;
    logic          load;

    // Shift register contents after taking rx_data_i; for one-byte words it is just the byte.
    generate
        if (WORD_BYTES == 1) begin : g_single
            assign sh_acc = rx_data_i;
        end else if (LSB_FIRST) begin : g_lsb
            assign sh_acc = {rx_data_i, sh_q[W-1:8]};
        end else begin : g_msb
            assign sh_acc = {sh_q[W-9:0], rx_data_i};
        end
    endgenerate

    always_comb begin
        accept      = rx_data_valid_i;
        complete    = accept && (byte_cnt_q == LAST_BYTE);
        transfer    = word_valid_q && word_ready_i;
        timeout_hit = (TIMEOUT_CYC != 0) && !accept && (byte_cnt_q != 16'd0)
                      && (idle_q == TO_LAST);
        // A byte arriving with the frame end is counted first, so it joins the dropped word.
        frame_drop  = rx_frame_end_i && (accept ? !complete : (byte_cnt_q != 16'd0));
        drop        = !complete && (frame_drop || timeout_hit);
        load        = complete && (!word_valid_q || transfer);
    end

    always_comb begin
        sh_d           = sh_q;
        byte_cnt_d     = byte_cnt_q;
        idle_d         = idle_q;
        word_data_d    = word_data_q;
        word_valid_d   = word_valid_q;
        partial_drop_d = drop;
        overflow_d     = complete && word_valid_q && !transfer;

        if (complete || drop) begin
            sh_d       = '0;
            byte_cnt_d = 16'd0;
        end else if (accept) begin
            sh_d       = sh_acc;
            byte_cnt_d = byte_cnt_q + 16'd1;
        end

        if ((TIMEOUT_CYC == 0) || accept || drop || (byte_cnt_q == 16'd0)) begin
            idle_d = '0;
        end else if (idle_q != '1) begin
            idle_d = idle_q + TW'(1);
        end

        if (load) begin
            word_data_d  = sh_acc;
            word_valid_d = 1'b1;
        end else if (transfer) begin
            word_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q           <= '0;
            byte_cnt_q     <= 16'd0;
            idle_q         <= '0;
            word_data_q    <= '0;
            word_valid_q   <= 1'b0;
            partial_drop_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            sh_q           <= sh_d;
            byte_cnt_q     <= byte_cnt_d;
            idle_q         <= idle_d;
            word_data_q    <= word_data_d;
            word_valid_q   <= word_valid_d;
            partial_drop_q <= partial_drop_d;
            overflow_q     <= overflow_d;
        end
    end

    assign word_data_o    = word_data_q;
    assign word_valid_o   = word_valid_q;
    assign byte_cnt_o     = byte_cnt_q;
    assign partial_drop_o = partial_drop_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench: MSB-first, LSB-first and one-byte-word packers share one input stream.
module tb_uart_rx_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_frame_end;
    logic        word_ready;

    logic [31:0] wd0, wd1;
    logic [7:0]  wd2;
    logic        wv0, wv1, wv2;
    logic [15:0] bc0, bc1, bc2;
    logic        pd0, pd1, pd2;
    logic        ov0, ov1, ov2;

    int errors = 0;
    int checks = 0;
    int xfer0  = 0;
    int xfer_base;

    always #5 clk = ~clk;

    uart_rx_word_packer #(.WORD_BYTES(4), .LSB_FIRST(1'b0), .TIMEOUT_CYC(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data), .rx_data_valid_i(rx_data_valid),
        .rx_frame_end_i(rx_frame_end), .word_ready_i(word_ready), .word_data_o(wd0),
        .word_valid_o(wv0), .byte_cnt_o(bc0), .partial_drop_o(pd0), .overflow_o(ov0));

    uart_rx_word_packer #(.WORD_BYTES(4), .LSB_FIRST(1'b1), .TIMEOUT_CYC(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data), .rx_data_valid_i(rx_data_valid),
        .rx_frame_end_i(rx_frame_end), .word_ready_i(word_ready), .word_data_o(wd1),
        .word_valid_o(wv1), .byte_cnt_o(bc1), .partial_drop_o(pd1), .overflow_o(ov1));

    uart_rx_word_packer #(.WORD_BYTES(1), .LSB_FIRST(1'b0), .TIMEOUT_CYC(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data), .rx_data_valid_i(rx_data_valid),
        .rx_frame_end_i(rx_frame_end), .word_ready_i(word_ready), .word_data_o(wd2),
        .word_valid_o(wv2), .byte_cnt_o(bc2), .partial_drop_o(pd2), .overflow_o(ov2));

    always @(posedge clk) begin
        if (wv0 && word_ready) xfer0 <= xfer0 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One byte strobe lasting exactly one active edge; returns on the following negedge.
    task automatic send_byte(input logic [7:0] b, input logic fe);
        @(negedge clk);
        rx_data       = b;
        rx_data_valid = 1'b1;
        rx_frame_end  = fe;
        @(negedge clk);
        rx_data_valid = 1'b0;
        rx_frame_end  = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        rx_frame_end  = 1'b0;
        word_ready    = 1'b1;

        // Reset state
        #12;
        chk("rst_wd",  wd0, 0);
        chk("rst_wv",  wv0, 0);
        chk("rst_bc",  bc0, 0);
        chk("rst_pd",  pd0, 0);
        chk("rst_ov",  ov0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1/2: MSB-first and LSB-first packing, ready high
        send_byte(8'h11, 1'b0);
        chk("t1_bc0_1", bc0, 1);
        chk("t2_bc1_1", bc1, 1);
        chk("t1_w2_11", wd2, 8'h11);
        send_byte(8'h22, 1'b0);
        chk("t2_bc1_2", bc1, 2);
        send_byte(8'h33, 1'b0);
        chk("t2_bc1_3", bc1, 3);
        chk("t1_wv_pre", wv0, 0);
        send_byte(8'h44, 1'b0);
        chk("t1_wv",    wv0, 1);
        chk("t1_wd",    wd0, 32'h11223344);
        chk("t2_wd",    wd1, 32'h44332211);
        chk("t2_bc1_0", bc1, 0);
        chk("t1_w2_44", wd2, 8'h44);
        @(negedge clk);
        chk("t1_wv_end", wv0, 0);
        chk("t1_w2_end", wv2, 0);

        // 3: ready low, two words, second one overflows
        word_ready = 1'b0;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hAC, 1'b0);
        send_byte(8'hAD, 1'b0);
        chk("t3_wv",  wv0, 1);
        chk("t3_wd",  wd0, 32'hAAABACAD);
        send_byte(8'hAE, 1'b0);
        send_byte(8'hAF, 1'b0);
        send_byte(8'hB0, 1'b0);
        chk("t3_ov_pre", ov0, 0);
        send_byte(8'hB1, 1'b0);
        chk("t3_ov",     ov0, 1);
        chk("t3_wd_kept", wd0, 32'hAAABACAD);
        chk("t3_wd1",    wd1, 32'hADACABAA);
        chk("t3_bc",     bc0, 0);
        @(negedge clk);
        chk("t3_ov_end", ov0, 0);
        chk("t3_wv_hold", wv0, 1);
        xfer_base  = xfer0;
        word_ready = 1'b1;
        @(negedge clk);
        chk("t3_wv_drop", wv0, 0);
        @(negedge clk);
        chk("t3_xfers", 64'(xfer0 - xfer_base), 1);

        // 4: frame end drops a partial word
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        chk("t4_bc2", bc0, 2);
        rx_frame_end = 1'b1;
        @(negedge clk);
        rx_frame_end = 1'b0;
        chk("t4_pd",   pd0, 1);
        chk("t4_bc0",  bc0, 0);
        chk("t4_pd_w1", pd2, 0);
        @(negedge clk);
        chk("t4_pd_end", pd0, 0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        chk("t4_wd", wd0, 32'h01020304);
        chk("t4_wv", wv0, 1);

        // 5: idle timeout after three bytes
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) chk("t5_pd_15", pd0, 0);
        end
        chk("t5_pd_16", pd0, 1);
        chk("t5_bc",    bc0, 0);
        @(negedge clk);
        chk("t5_pd_17", pd0, 0);
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hB3, 1'b0);
        send_byte(8'hC4, 1'b1);
        chk("t5_fe_wd", wd0, 32'hB1B2B3C4);
        chk("t5_fe_wv", wv0, 1);
        chk("t5_fe_pd", pd0, 0);

        // 6: asynchronous reset mid-word with a held word
        word_ready = 1'b0;
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h24, 1'b0);
        send_byte(8'h25, 1'b0);
        send_byte(8'h26, 1'b0);
        chk("t6_wv_pre", wv0, 1);
        chk("t6_bc_pre", bc0, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_wv", wv0, 0);
        chk("t6_wd", wd0, 0);
        chk("t6_bc", bc0, 0);
        chk("t6_pd", pd0, 0);
        chk("t6_ov", ov0, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        word_ready = 1'b1;
        send_byte(8'h0D, 1'b0);
        send_byte(8'h0E, 1'b0);
        send_byte(8'h0F, 1'b0);
        send_byte(8'h10, 1'b0);
        chk("t6_wd_post", wd0, 32'h0D0E0F10);
        chk("t6_wd1_post", wd1, 32'h100F0E0D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
